// File: rtl/sr_drift_multimode.sv
// Multi-channel Schumann Resonance drift engine: bounded per-channel offsets added to fixed
// centers, advanced on per-channel period events in hold / walk / slew / common-mode.
module sr_drift_multimode #(
  parameter int unsigned                  WIDTH         = 18,
  parameter int unsigned                  FRAC          = 14,
  parameter int unsigned                  NUM_CH        = 5,
  parameter logic [NUM_CH*WIDTH-1:0]      CENTER_PACKED = {18'd823, 18'd643, 18'd514,
                                                           18'd354, 18'd199},
  parameter logic [NUM_CH*WIDTH-1:0]      BOUND_PACKED  = {18'd51, 18'd39, 18'd26,
                                                           18'd21, 18'd13},
  parameter int unsigned                  PERIOD_W      = 16,
  parameter logic [NUM_CH*PERIOD_W-1:0]   PERIOD_PACKED = {16'd5, 16'd8, 16'd16,
                                                           16'd6, 16'd4},
  parameter int unsigned                  STEP          = 1,
  parameter logic [31:0]                  LFSR_SEED     = 32'hACE1_2468
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_en,
  input  logic [1:0]                mode,
  input  logic                      target_valid,
  output logic                      target_ready,
  input  logic [3:0]                target_ch,
  input  logic [WIDTH-1:0]          target_offset,
  output logic [NUM_CH*WIDTH-1:0]   omega_dt_packed,
  output logic [NUM_CH*WIDTH-1:0]   drift_offset_packed,
  output logic [NUM_CH-1:0]         step_strobe,
  output logic [NUM_CH-1:0]         at_bound,
  output logic                      bad_ch_err
);

  typedef enum logic [1:0] {
    ModeHold   = 2'b00,
    ModeWalk   = 2'b01,
    ModeSlew   = 2'b10,
    ModeCommon = 2'b11
  } mode_e;

  // Galois mask for x^32 + x^22 + x^2 + x + 1, shifting right.
  localparam logic [31:0]          LfsrTaps = 32'h8020_0003;
  localparam logic [31:0]          SeedEff  = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
  localparam logic signed [WIDTH:0] StepX   = (WIDTH+1)'(STEP);

  // FRAC only documents the Q-format; nothing is rescaled internally.
  if (FRAC >= WIDTH) begin : g_frac_note
  end

  function automatic logic [WIDTH-1:0] center_of(input int unsigned ch);
    return CENTER_PACKED[ch*WIDTH +: WIDTH];
  endfunction

  function automatic logic signed [WIDTH:0] bound_of(input int unsigned ch);
    return {1'b0, BOUND_PACKED[ch*WIDTH +: WIDTH]};
  endfunction

  function automatic logic [PERIOD_W-1:0] period_m1(input int unsigned ch);
    return PERIOD_PACKED[ch*PERIOD_W +: PERIOD_W] - 1'b1;
  endfunction

  logic signed [WIDTH-1:0] off_q   [NUM_CH];
  logic signed [WIDTH-1:0] off_d   [NUM_CH];
  logic signed [WIDTH-1:0] tgt_q   [NUM_CH];
  logic signed [WIDTH-1:0] tgt_d   [NUM_CH];
  logic [WIDTH-1:0]        omega_q [NUM_CH];
  logic [WIDTH-1:0]        omega_d [NUM_CH];
  logic [PERIOD_W-1:0]     cnt_q   [NUM_CH];
  logic [PERIOD_W-1:0]     cnt_d   [NUM_CH];

  logic [NUM_CH-1:0] strobe_q, strobe_d;
  logic [NUM_CH-1:0] atb_q, atb_d;
  logic [NUM_CH-1:0] ev;
  logic [31:0]       lfsr_q, lfsr_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              pend_valid_q, pend_valid_d;
  logic [3:0]        pend_ch_q, pend_ch_d;
  logic [WIDTH-1:0]  pend_off_q, pend_off_d;
  logic              accept, ch_ok;

  logic signed [WIDTH:0] off_x, tgt_x, bnd_x, nbnd_x, up_x, dn_x, new_x, diff_x;
  logic signed [WIDTH:0] pend_x, clamp_x;

  always_comb begin
    lfsr_d = lfsr_q;
    if (clk_en) begin
      lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrTaps : 32'd0);
    end

    // Every accept, good or bad channel, costs exactly one not-ready cycle.
    accept       = target_valid && ready_q;
    ch_ok        = (32'(target_ch) < NUM_CH);
    ready_d      = !accept;
    pend_valid_d = accept && ch_ok;
    pend_ch_d    = accept ? target_ch : pend_ch_q;
    pend_off_d   = accept ? target_offset : pend_off_q;
    err_d        = err_q || (accept && !ch_ok);
    pend_x       = {pend_off_q[WIDTH-1], pend_off_q};

    ev       = '0;
    strobe_d = '0;
    atb_d    = '0;
    off_x    = '0;
    tgt_x    = '0;
    bnd_x    = '0;
    nbnd_x   = '0;
    up_x     = '0;
    dn_x     = '0;
    new_x    = '0;
    diff_x   = '0;
    clamp_x  = '0;

    for (int i = 0; i < int'(NUM_CH); i++) begin
      ev[i]    = clk_en && (cnt_q[i] == period_m1(i));
      cnt_d[i] = cnt_q[i];
      if (clk_en) begin
        cnt_d[i] = ev[i] ? '0 : cnt_q[i] + 1'b1;
      end

      off_x  = {off_q[i][WIDTH-1], off_q[i]};
      tgt_x  = {tgt_q[i][WIDTH-1], tgt_q[i]};
      bnd_x  = bound_of(i);
      nbnd_x = -bnd_x;
      up_x   = off_x + StepX;
      dn_x   = off_x - StepX;
      diff_x = tgt_x - off_x;
      new_x  = off_x;

      if (ev[i]) begin
        unique case (mode_e'(mode))
          ModeHold: begin
            new_x = off_x;
          end
          ModeWalk: begin
            strobe_d[i] = 1'b1;
            if (lfsr_q[i]) new_x = (up_x > bnd_x) ? dn_x : up_x;
            else           new_x = (dn_x < nbnd_x) ? up_x : dn_x;
          end
          ModeSlew: begin
            strobe_d[i] = 1'b1;
            if (diff_x > StepX)       new_x = up_x;
            else if (diff_x < -StepX) new_x = dn_x;
            else                      new_x = tgt_x;
          end
          ModeCommon: begin
            strobe_d[i] = 1'b1;
            if (lfsr_q[0]) new_x = (up_x > bnd_x) ? bnd_x : up_x;
            else           new_x = (dn_x < nbnd_x) ? nbnd_x : dn_x;
          end
        endcase
      end

      off_d[i]   = new_x[WIDTH-1:0];
      omega_d[i] = center_of(i) + new_x[WIDTH-1:0];
      atb_d[i]   = (new_x == bnd_x) || (new_x == nbnd_x);

      // Target write lands after this cycle's event, so a coinciding event sees the old target.
      clamp_x = (pend_x > bnd_x) ? bnd_x : ((pend_x < nbnd_x) ? nbnd_x : pend_x);
      tgt_d[i] = tgt_q[i];
      if (pend_valid_q && (pend_ch_q == 4'(i))) begin
        tgt_d[i] = clamp_x[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q       <= SeedEff;
      ready_q      <= 1'b1;
      err_q        <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_ch_q    <= '0;
      pend_off_q   <= '0;
      strobe_q     <= '0;
      atb_q        <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        off_q[i]   <= '0;
        tgt_q[i]   <= '0;
        cnt_q[i]   <= '0;
        omega_q[i] <= center_of(i);
      end
    end else begin
      lfsr_q       <= lfsr_d;
      ready_q      <= ready_d;
      err_q        <= err_d;
      pend_valid_q <= pend_valid_d;
      pend_ch_q    <= pend_ch_d;
      pend_off_q   <= pend_off_d;
      strobe_q     <= strobe_d;
      atb_q        <= atb_d;
      off_q        <= off_d;
      tgt_q        <= tgt_d;
      cnt_q        <= cnt_d;
      omega_q      <= omega_d;
    end
  end

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_pack
    assign omega_dt_packed[g*WIDTH +: WIDTH]     = omega_q[g];
    assign drift_offset_packed[g*WIDTH +: WIDTH] = off_q[g];
  end

  assign step_strobe  = strobe_q;
  assign at_bound     = atb_q;
  assign target_ready = ready_q;
  assign bad_ch_err   = err_q;

endmodule

// File: tb/tb_sr_drift_multimode.sv
// Scoreboard bench for sr_drift_multimode: a reference model queues the expected outputs of
// every cycle, a negedge monitor pops and compares; directed checks cover the headline cases.
module tb_sr_drift_multimode;

  localparam int W = 18;
  localparam int N = 5;

  int center [N] = '{199, 354, 514, 643, 823};
  int bound  [N] = '{13, 21, 26, 39, 51};
  int period [N] = '{4, 6, 16, 8, 5};

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           clk_en = 1'b0;
  logic [1:0]     mode = 2'b00;
  logic           target_valid = 1'b0;
  logic           target_ready;
  logic [3:0]     target_ch = 4'd0;
  logic [W-1:0]   target_offset = '0;
  logic [N*W-1:0] omega_dt_packed;
  logic [N*W-1:0] drift_offset_packed;
  logic [N-1:0]   step_strobe;
  logic [N-1:0]   at_bound;
  logic           bad_ch_err;

  sr_drift_multimode dut (
    .clk                 (clk),
    .rst                 (rst),
    .clk_en              (clk_en),
    .mode                (mode),
    .target_valid        (target_valid),
    .target_ready        (target_ready),
    .target_ch           (target_ch),
    .target_offset       (target_offset),
    .omega_dt_packed     (omega_dt_packed),
    .drift_offset_packed (drift_offset_packed),
    .step_strobe         (step_strobe),
    .at_bound            (at_bound),
    .bad_ch_err          (bad_ch_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  function automatic void chk(input bit ok, input string name,
                              input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endfunction

  typedef struct packed {
    logic [N*W-1:0] offs;
    logic [N-1:0]   strobe;
    logic [N-1:0]   atb;
    logic           ready;
    logic           err;
  } exp_t;

  exp_t sb_q [$];

  // Reference model state
  int       m_off [N];
  int       m_tgt [N];
  int       m_cnt [N];
  bit [31:0] m_lfsr;
  bit       m_pv;
  int       m_pch;
  int       m_poff;
  bit       m_ready;
  bit       m_err;
  bit [N-1:0] m_strobe;
  bit [N-1:0] m_atb;

  always @(posedge clk or posedge rst) begin : model
    exp_t      e;
    bit [31:0] lf;
    bit        evt;
    int        nv;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_off[i] = 0; m_tgt[i] = 0; m_cnt[i] = 0;
      end
      m_lfsr = 32'hACE1_2468; m_pv = 0; m_pch = 0; m_poff = 0;
      m_ready = 1; m_err = 0; m_strobe = '0; m_atb = '0;
      sb_q.delete();
    end else begin
      lf = m_lfsr;
      m_strobe = '0;
      for (int i = 0; i < N; i++) begin
        evt = clk_en && (m_cnt[i] == period[i] - 1);
        if (clk_en) m_cnt[i] = evt ? 0 : m_cnt[i] + 1;
        if (evt) begin
          nv = m_off[i];
          case (mode)
            2'b01: begin
              m_strobe[i] = 1;
              if (lf[i]) nv = (m_off[i] + 1 > bound[i]) ? m_off[i] - 1 : m_off[i] + 1;
              else       nv = (m_off[i] - 1 < -bound[i]) ? m_off[i] + 1 : m_off[i] - 1;
            end
            2'b10: begin
              m_strobe[i] = 1;
              if (m_tgt[i] > m_off[i])      nv = m_off[i] + 1;
              else if (m_tgt[i] < m_off[i]) nv = m_off[i] - 1;
            end
            2'b11: begin
              m_strobe[i] = 1;
              if (lf[0]) nv = (m_off[i] + 1 > bound[i]) ? bound[i] : m_off[i] + 1;
              else       nv = (m_off[i] - 1 < -bound[i]) ? -bound[i] : m_off[i] - 1;
            end
            default: nv = m_off[i];
          endcase
          m_off[i] = nv;
        end
        m_atb[i] = (m_off[i] == bound[i]) || (m_off[i] == -bound[i]);
      end
      if (m_pv) begin
        if (m_poff > bound[m_pch])       m_tgt[m_pch] = bound[m_pch];
        else if (m_poff < -bound[m_pch]) m_tgt[m_pch] = -bound[m_pch];
        else                             m_tgt[m_pch] = m_poff;
        m_pv = 0;
      end
      if (target_valid && m_ready) begin
        if (int'(target_ch) < N) begin
          m_pv = 1; m_pch = int'(target_ch); m_poff = $signed(target_offset);
        end else begin
          m_err = 1;
        end
        m_ready = 0;
      end else begin
        m_ready = 1;
      end
      if (clk_en) m_lfsr = {1'b0, lf[31:1]} ^ (lf[0] ? 32'h8020_0003 : 32'h0);
      e.offs = '0;
      for (int i = 0; i < N; i++) e.offs[i*W +: W] = W'(m_off[i]);
      e.strobe = m_strobe; e.atb = m_atb; e.ready = m_ready; e.err = m_err;
      sb_q.push_back(e);
    end
  end

  bit rw_phase = 0;
  bit cm_phase = 0;
  bit saw_atb0 = 0;
  int rw_min [N];
  int rw_max [N];

  always @(negedge clk) begin : monitor
    exp_t           e;
    logic [N*W-1:0] eo;
    bit             inb;
    int             v;
    if (!rst && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(drift_offset_packed == e.offs, "offsets", drift_offset_packed, e.offs);
      eo = '0;
      for (int i = 0; i < N; i++) eo[i*W +: W] = W'(center[i] + $signed(e.offs[i*W +: W]));
      chk(omega_dt_packed == eo, "omega", omega_dt_packed, eo);
      chk(step_strobe == e.strobe, "strobe", step_strobe, e.strobe);
      chk(at_bound == e.atb, "at_bound", at_bound, e.atb);
      chk(target_ready == e.ready, "target_ready", target_ready, e.ready);
      chk(bad_ch_err == e.err, "bad_ch_err", bad_ch_err, e.err);
      inb = 1;
      for (int i = 0; i < N; i++) begin
        v = $signed(drift_offset_packed[i*W +: W]);
        if (v > bound[i] || v < -bound[i]) inb = 0;
        if (rw_phase) begin
          if (v < rw_min[i]) rw_min[i] = v;
          if (v > rw_max[i]) rw_max[i] = v;
        end
      end
      chk(inb, "offset_within_bound", drift_offset_packed, 0);
      if (cm_phase && at_bound[0]) saw_atb0 = 1;
    end
  end

  function automatic int off_of(input int i);
    return $signed(drift_offset_packed[i*W +: W]);
  endfunction

  task automatic cyc(input bit en);
    clk_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic load(input int ch, input int off);
    int n;
    target_valid  = 1'b1;
    target_ch     = 4'(ch);
    target_offset = W'(off);
    n = 0;
    while (!target_ready && n < 4) begin
      cyc(1'b0);
      n++;
    end
    chk(target_ready == 1'b1, "load_ready_wait", target_ready, 1);
    cyc(1'b0);
    target_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*W-1:0] omega_rst;
    int             n;
    omega_rst = {18'd823, 18'd643, 18'd514, 18'd354, 18'd199};

    // Reset and idle
    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) cyc(1'b0);
    chk(omega_dt_packed == omega_rst, "rst_omega", omega_dt_packed, omega_rst);
    chk(drift_offset_packed == '0, "rst_offsets", drift_offset_packed, 0);
    chk(target_ready == 1'b1, "rst_ready", target_ready, 1);
    chk(step_strobe == '0, "rst_strobe", step_strobe, 0);

    // Bad channel: accepted, dropped, sticky error, no target change
    load(7, 5);
    chk(target_ready == 1'b0, "bad_ready_low", target_ready, 0);
    chk(bad_ch_err == 1'b1, "bad_err_set", bad_ch_err, 1);
    cyc(1'b0);
    chk(target_ready == 1'b1, "bad_ready_high", target_ready, 1);
    mode = 2'b10;
    repeat (100) cyc(1'b1);
    chk(drift_offset_packed == '0, "bad_no_target", drift_offset_packed, 0);
    chk(bad_ch_err == 1'b1, "bad_err_sticky", bad_ch_err, 1);

    // Slew: ch2 target clamps to 26, one step per 16 ticks; back-to-back loads on ch1, ch3
    do_reset();
    mode = 2'b10;
    load(2, 100);
    chk(target_ready == 1'b0, "slew_ready_low", target_ready, 0);
    load(1, -5);
    load(3, 7);
    repeat (160) cyc(1'b1);
    chk(off_of(2) == 10, "slew_ch2_160", off_of(2), 10);
    chk(off_of(1) == -5, "slew_ch1", off_of(1), -5);
    chk(off_of(3) == 7, "slew_ch3", off_of(3), 7);
    repeat (290) cyc(1'b1);
    chk(off_of(2) == 26, "slew_ch2_clamp", off_of(2), 26);
    chk(at_bound[2] == 1'b1, "slew_ch2_at_bound", at_bound[2], 1);
    chk(omega_dt_packed[2*W +: W] == 18'd540, "slew_ch2_omega", omega_dt_packed[2*W +: W], 540);

    // Common-mode walk from reset
    do_reset();
    mode = 2'b11;
    cm_phase = 1;
    repeat (8000) cyc(1'b1);
    cm_phase = 0;
    chk(saw_atb0 == 1'b1, "cm_ch0_saturates", saw_atb0, 1);

    // Random walk
    do_reset();
    for (int i = 0; i < N; i++) begin
      rw_min[i] = 0;
      rw_max[i] = 0;
    end
    mode = 2'b01;
    rw_phase = 1;
    repeat (40000) cyc(1'b1);
    rw_phase = 0;
    for (int i = 0; i < N; i++) begin
      chk(rw_max[i] - rw_min[i] > 2, "rw_span", rw_max[i] - rw_min[i], 3);
    end

    // Reset in the middle of a walk with a load pending
    target_valid  = 1'b1;
    target_ch     = 4'd1;
    target_offset = W'(3);
    cyc(1'b1);
    target_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk(drift_offset_packed == '0, "async_rst_offsets", drift_offset_packed, 0);
    chk(omega_dt_packed == omega_rst, "async_rst_omega", omega_dt_packed, omega_rst);
    @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    for (int k = 1; k <= 10 && n == 0; k++) begin
      cyc(1'b1);
      if (step_strobe[0]) n = k;
    end
    chk(n == 4, "cadence_ch0_first", n, 4);

    // Pending load was discarded: slew toward zero targets leaves offsets near zero
    mode = 2'b10;
    repeat (200) cyc(1'b1);
    chk(drift_offset_packed == '0, "pending_discarded", drift_offset_packed, 0);

    cyc(1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
